// File: rtl/mac_seq_pkg.sv
// Shared types and default sizing for the MAC sample sequencer.
package mac_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHold = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DEPTH   = 3;
    localparam logic [31:0] DEF_TIMEOUT = 32'h0300_0000;

endpackage

// File: rtl/mac_seq_loader_if.sv
// Bundle of sample stream, engine write/run port, result stream and status
// signals between the host and the MAC sequencer.
interface mac_seq_loader_if
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] mac_index;
    logic [DATA_W-1:0] mac_data;
    logic              mac_we;
    logic              mac_run;
    logic              mac_done;
    logic [DATA_W-1:0] mac_result;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              busy;
    logic              timeout_err;

    // Host / engine side: drives stimulus, observes the sequencer
    modport master (
        output start, s_valid, s_data, mac_done, mac_result, r_ready,
        input  s_ready, mac_index, mac_data, mac_we, mac_run, r_valid, r_data, busy,
        input  timeout_err
    );

    // Sequencer side
    modport slave (
        input  start, s_valid, s_data, mac_done, mac_result, r_ready,
        output s_ready, mac_index, mac_data, mac_we, mac_run, r_valid, r_data, busy,
        output timeout_err
    );
endinterface

// File: rtl/mac_seq_loader.sv
// Host-side sequencer for the MAC engine: loads DEPTH samples into the engine
// RAM, runs the engine until done, then presents the result.
// Optional watchdog on the RUN phase is enabled by defining MAC_SEQ_WATCHDOG_EN.
module mac_seq_loader
    import mac_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
    input logic             clk,
    input logic             rst,
    mac_seq_loader_if.slave bus
);
    // Counter wraps modulo 2**ADDR_W, so DEPTH == 2**ADDR_W ends on the all-ones index
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_mac_index;
    logic [DATA_W-1:0] r_mac_data;
    logic              r_mac_we;
    logic              r_mac_run;
    logic              r_r_valid;
    logic [DATA_W-1:0] r_r_data;
    logic              r_timeout_err;
`ifdef MAC_SEQ_WATCHDOG_EN
    logic [31:0]       r_wd_cnt;
`else
    logic              w_unused_timeout;
`endif

    // Sequencer FSM with all engine/result outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_count       <= '0;
            r_mac_index   <= '0;
            r_mac_data    <= '0;
            r_mac_we      <= 1'b0;
            r_mac_run     <= 1'b0;
            r_r_valid     <= 1'b0;
            r_r_data      <= '0;
            r_timeout_err <= 1'b0;
`ifdef MAC_SEQ_WATCHDOG_EN
            r_wd_cnt      <= '0;
`endif
        end else begin
            r_mac_we <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state       <= StLoad;
                        r_count       <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                StLoad: begin
                    // s_ready is high throughout LOAD, so s_valid alone is the handshake
                    if (bus.s_valid) begin
                        r_mac_we    <= 1'b1;
                        r_mac_index <= r_count;
                        r_mac_data  <= bus.s_data;
                        r_count     <= r_count + 1'b1;
                        if (r_count == LastIdx) begin
                            r_state   <= StRun;
                            r_mac_run <= 1'b1;
`ifdef MAC_SEQ_WATCHDOG_EN
                            r_wd_cnt  <= '0;
`endif
                        end
                    end
                end
                StRun: begin
                    // done takes priority over a coincident timeout
                    if (bus.mac_done) begin
                        r_r_data  <= bus.mac_result;
                        r_r_valid <= 1'b1;
                        r_mac_run <= 1'b0;
                        r_state   <= StHold;
                    end
`ifdef MAC_SEQ_WATCHDOG_EN
                    else if (r_wd_cnt == TIMEOUT - 32'd1) begin
                        r_timeout_err <= 1'b1;
                        r_mac_run     <= 1'b0;
                        r_state       <= StIdle;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 32'd1;
                    end
`endif
                end
                StHold: begin
                    if (bus.r_ready) begin
                        r_r_valid <= 1'b0;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifndef MAC_SEQ_WATCHDOG_EN
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // s_ready falls on the edge that accepts the last sample since state leaves LOAD
    assign bus.s_ready     = (r_state == StLoad);
    assign bus.busy        = (r_state != StIdle);
    assign bus.mac_index   = r_mac_index;
    assign bus.mac_data    = r_mac_data;
    assign bus.mac_we      = r_mac_we;
    assign bus.mac_run     = r_mac_run;
    assign bus.r_valid     = r_r_valid;
    assign bus.r_data      = r_r_data;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mac_seq_loader.sv
// Directed self-checking bench for mac_seq_loader (DEPTH=3, TIMEOUT=16).
module tb_mac_seq_loader;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mac_seq_loader_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mac_seq_loader #(
        .DATA_W (8),
        .ADDR_W (8),
        .DEPTH  (3),
        .TIMEOUT(32'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] samples [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        samples[0] = 8'h05;
        samples[1] = 8'h07;
        samples[2] = 8'h09;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h00;
        bus.mac_done   = 1'b0;
        bus.mac_result = 8'h00;
        bus.r_ready    = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_mac_we", bus.mac_we, 0);
        check("rst_mac_run", bus.mac_run, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_r_data", bus.r_data, 0);
        check("rst_timeout_err", bus.timeout_err, 0);

        // Burst with s_valid held high
        rst = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load_busy", bus.busy, 1);
        check("load_s_ready", bus.s_ready, 1);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.s_data = samples[i];
            tick();
            check("c_we", bus.mac_we, 1);
            check("c_index", bus.mac_index, i);
            check("c_data", bus.mac_data, samples[i]);
        end
        check("c_run_rise", bus.mac_run, 1);
        check("c_s_ready_low", bus.s_ready, 0);
        bus.s_valid = 1'b0;
        tick();
        check("c_we_drop", bus.mac_we, 0);
        check("c_index_hold", bus.mac_index, 2);
        check("c_data_hold", bus.mac_data, 8'h09);
        check("c_run_stay", bus.mac_run, 1);

        // Result held while consumer stalls; start in HOLD ignored
        bus.mac_done   = 1'b1;
        bus.mac_result = 8'h2A;
        tick();
        bus.mac_done   = 1'b0;
        bus.mac_result = 8'h55;
        check("hold_run_drop", bus.mac_run, 0);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            check("hold_r_valid", bus.r_valid, 1);
            check("hold_r_data", bus.r_data, 8'h2A);
            check("hold_busy", bus.busy, 1);
        end
        bus.r_ready = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        bus.start   = 1'b0;
        check("rh_r_valid", bus.r_valid, 0);
        check("rh_busy", bus.busy, 0);
        tick();
        check("rh_start_ignored", bus.busy, 0);

        // mac_done while idle has no effect
        bus.mac_done = 1'b1;
        tick();
        bus.mac_done = 1'b0;
        check("idle_done_busy", bus.busy, 0);
        check("idle_done_r_valid", bus.r_valid, 0);
        check("idle_done_run", bus.mac_run, 0);

        // Burst with s_valid toggling and a start pulse during LOAD
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.start   = (i == 0);
            bus.s_valid = 1'b0;
            tick();
            bus.start = 1'b0;
            check("t_gap_we", bus.mac_we, 0);
            check("t_gap_s_ready", bus.s_ready, 1);
            bus.s_valid = 1'b1;
            bus.s_data  = samples[i];
            tick();
            check("t_we", bus.mac_we, 1);
            check("t_index", bus.mac_index, i);
            check("t_data", bus.mac_data, samples[i]);
        end
        check("t_s_ready_low", bus.s_ready, 0);
        check("t_run", bus.mac_run, 1);
        bus.s_data = 8'hEE;
        tick();
        bus.s_valid = 1'b0;
        check("t_no_extra_we", bus.mac_we, 0);
        check("t_no_extra_index", bus.mac_index, 2);
        bus.mac_done   = 1'b1;
        bus.mac_result = 8'h11;
        tick();
        bus.mac_done = 1'b0;
        check("t_r_data", bus.r_data, 8'h11);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        check("t_idle", bus.busy, 0);

        // Reset mid-burst
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h21;
        tick();
        bus.s_data = 8'h22;
        tick();
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_we", bus.mac_we, 0);
        check("mr_index", bus.mac_index, 0);
        check("mr_data", bus.mac_data, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_s_ready", bus.s_ready, 0);
        check("mr_r_data", bus.r_data, 0);
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.s_data = 8'h30 + 8'(i);
            tick();
            check("mr2_index", bus.mac_index, i);
            check("mr2_data", bus.mac_data, 8'h30 + i);
        end
        bus.s_valid = 1'b0;
        check("mr2_run", bus.mac_run, 1);

        // RUN without mac_done
`ifdef MAC_SEQ_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("wd_r_valid", bus.r_valid, 0);
        end
        check("wd_run_before", bus.mac_run, 1);
        check("wd_err_before", bus.timeout_err, 0);
        tick();
        check("wd_err", bus.timeout_err, 1);
        check("wd_run_drop", bus.mac_run, 0);
        check("wd_busy", bus.busy, 0);
        check("wd_r_valid_after", bus.r_valid, 0);
        tick();
        check("wd_err_sticky", bus.timeout_err, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("wd_err_clear", bus.timeout_err, 0);
        check("wd_restart_busy", bus.busy, 1);
`else
        repeat (40) tick();
        check("nowd_run", bus.mac_run, 1);
        check("nowd_busy", bus.busy, 1);
        check("nowd_err", bus.timeout_err, 0);
        check("nowd_r_valid", bus.r_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
